class_assoc_search: RTL and testbench

// - Associative-search stage directly downstream of the class hypervector generator (class_hvec_gen).
// - Buffers one encoded query hypervector, delivered as N_FRAMES parallel frames of DI_PARALLEL_W_BITS.
// - Sweeps every (class, frame) address of the class generator and accumulates Hamming distance per class.
// - Reports the class with minimum total distance; this is the inference result of the HDC classifier.

---
 rtl/class_assoc_search.sv | 139 +++++++++++++
 tb/tb_class_assoc_search.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/class_assoc_search.sv
// Associative search behind class_hvec_gen: buffers one query hypervector, sweeps all
// (class, frame) addresses, accumulates per-class Hamming distance and reports the argmin class.
module class_assoc_search #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3,
  parameter int CLASS_ID_W         = 3,
  parameter int FRAME_IDX_W        = 2,
  localparam int DIST_W            = $clog2(N_FRAMES*DI_PARALLEL_W_BITS+1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_frame_in,
  input  logic                          query_valid,
  output logic                          query_ready,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          pred_valid,
  input  logic                          pred_ready,
  output logic [CLASS_ID_W-1:0]         pred_class,
  output logic [DIST_W-1:0]             pred_dist
);

  localparam int W = DI_PARALLEL_W_BITS;

  typedef enum logic [1:0] {LOAD, SEARCH, DRAIN, DONE} state_t;

  state_t                         state, state_n;
  logic [N_FRAMES-1:0][W-1:0]     qbuf;
  logic [FRAME_IDX_W-1:0]         ld_cnt;
  logic [CLASS_ID_W-1:0]          c;
  logic [FRAME_IDX_W-1:0]         f;

  // stage 1 registers
  logic                           s1_vld;
  logic [DIST_W-1:0]              pc_q;
  logic [CLASS_ID_W-1:0]          c_q;
  logic                           last_q;

  // stage 2 state
  logic [DIST_W-1:0]              acc;
  logic [DIST_W-1:0]              best_dist, best_dist_n;
  logic [CLASS_ID_W-1:0]          best_class, best_class_n;
  logic [DIST_W-1:0]              total;
  logic                           take;

  logic                           ld_fire, ld_last, f_last, addr_last;

  function automatic logic [DIST_W-1:0] popcnt(input logic [W-1:0] x);
    logic [DIST_W-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) n = n + DIST_W'(x[i]);
    return n;
  endfunction

  assign query_ready = (state == LOAD) && !rst;
  assign ld_fire     = query_valid && query_ready;
  assign ld_last     = (ld_cnt == FRAME_IDX_W'(N_FRAMES-1));
  assign f_last      = (f == FRAME_IDX_W'(N_FRAMES-1));
  assign addr_last   = f_last && (c == CLASS_ID_W'(N_CLASSES-1));

  assign frame_id    = (state == SEARCH) ? c : '0;
  assign frame_index = (state == SEARCH) ? f : '0;

  // Class 0 always seeds best, so nothing from a previous query leaks in.
  assign total        = acc + pc_q;
  assign take         = s1_vld && last_q && ((c_q == '0) || (total < best_dist));
  assign best_dist_n  = take ? total : best_dist;
  assign best_class_n = take ? c_q   : best_class;

  always_comb begin
    state_n = state;
    case (state)
      LOAD:    if (ld_fire && ld_last) state_n = SEARCH;
      SEARCH:  if (addr_last)          state_n = DRAIN;
      DRAIN:                           state_n = DONE;
      DONE:    if (pred_ready)         state_n = LOAD;
      default:                         state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      qbuf       <= '0;
      ld_cnt     <= '0;
      c          <= '0;
      f          <= '0;
      s1_vld     <= 1'b0;
      pc_q       <= '0;
      c_q        <= '0;
      last_q     <= 1'b0;
      acc        <= '0;
      best_dist  <= '0;
      best_class <= '0;
      pred_valid <= 1'b0;
      pred_class <= '0;
      pred_dist  <= '0;
    end else begin
      state <= state_n;

      if (ld_fire) begin
        qbuf[ld_cnt] <= query_frame_in;
        ld_cnt       <= ld_last ? '0 : ld_cnt + 1'b1;
      end

      if (state == SEARCH) begin
        if (f_last) begin
          f <= '0;
          c <= addr_last ? '0 : c + 1'b1;
        end else begin
          f <= f + 1'b1;
        end
      end

      s1_vld <= (state == SEARCH);
      pc_q   <= popcnt(qbuf[f] ^ class_vec_in);
      c_q    <= c;
      last_q <= f_last;

      if (s1_vld) begin
        acc        <= last_q ? '0 : total;
        best_dist  <= best_dist_n;
        best_class <= best_class_n;
      end

      // DRAIN takes the bypassed best so the final class update is not lost.
      if (state == DRAIN) begin
        pred_valid <= 1'b1;
        pred_class <= best_class_n;
        pred_dist  <= best_dist_n;
      end else if (state == DONE && pred_ready) begin
        pred_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_class_assoc_search.sv
// Directed bench for class_assoc_search: class_hvec_gen stub memory plus an argmin reference model.
module tb_class_assoc_search;

  localparam int W  = 64;
  localparam int NC = 8;
  localparam int NF = 3;
  localparam int CW = 3;
  localparam int FW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  query_frame_in = '0;
  logic          query_valid = 1'b0;
  logic          query_ready;
  logic [CW-1:0] frame_id;
  logic [FW-1:0] frame_index;
  logic [W-1:0]  class_vec_in;
  logic          pred_valid;
  logic          pred_ready = 1'b0;
  logic [CW-1:0] pred_class;
  logic [DW-1:0] pred_dist;

  class_assoc_search dut (
    .clk(clk), .rst(rst),
    .query_frame_in(query_frame_in), .query_valid(query_valid), .query_ready(query_ready),
    .frame_id(frame_id), .frame_index(frame_index), .class_vec_in(class_vec_in),
    .pred_valid(pred_valid), .pred_ready(pred_ready),
    .pred_class(pred_class), .pred_dist(pred_dist)
  );

  always #5 clk = ~clk;

  logic [W-1:0] cmem [NC][NF];
  logic [W-1:0] qv   [NF];
  assign class_vec_in = (int'(frame_index) < NF) ? cmem[frame_id][frame_index] : '0;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int exp_class = 0;
  int exp_dist  = 0;
  logic chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: sum of per-frame Hamming distances, strict-less argmin.
  function automatic void model();
    int best, bc, d;
    best = 0; bc = 0;
    for (int k = 0; k < NC; k++) begin
      d = 0;
      for (int j = 0; j < NF; j++) d += $countones(qv[j] ^ cmem[k][j]);
      if (k == 0 || d < best) begin best = d; bc = k; end
    end
    exp_class = bc;
    exp_dist  = best;
  endfunction

  function automatic logic [W-1:0] ones(input int k);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < k && i < W; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Prediction checks on every cycle it is presented.
  always @(negedge clk) begin
    if (chk_en && pred_valid) begin
      chk("pred_class", pred_class, exp_class);
      chk("pred_dist", pred_dist, exp_dist);
      chk("ready_low_in_done", query_ready, 0);
    end
  end

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_query_ready"}, query_ready, 0);
    chk({tag, "_pred_valid"}, pred_valid, 0);
    chk({tag, "_frame_id"}, frame_id, 0);
    chk({tag, "_frame_index"}, frame_index, 0);
    chk({tag, "_pred_class"}, pred_class, 0);
    chk({tag, "_pred_dist"}, pred_dist, 0);
  endtask

  // All tasks start and end at a falling edge.
  task automatic do_reset();
    rst = 1'b1; query_valid = 1'b0; pred_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", query_ready, 1);
  endtask

  task automatic load(input logic [15:0] pat, output int hs);
    int k;
    logic v;
    k = 0; hs = 0;
    for (int i = 0; i < 40 && k < NF; i++) begin
      v = (i < 16) ? pat[i] : 1'b1;
      query_valid    = v;
      query_frame_in = v ? qv[k] : (64'hBAD0_BAD0_BAD0_BAD0 ^ 64'(i));
      if (v && query_ready) begin
        if (k == NF-1) hs = cyc + 1;
        k++;
      end
      @(negedge clk);
    end
    query_valid = 1'b0;
    query_frame_in = '0;
    chk("frames_loaded", k, NF);
  endtask

  task automatic run_sweep(input int hs);
    int i, addr_err, rdy_err, eid, eix;
    i = 0; addr_err = 0; rdy_err = 0;
    while (!pred_valid && i < 60) begin
      eid = (i < NC*NF) ? i / NF : 0;
      eix = (i < NC*NF) ? i % NF : 0;
      if (int'(frame_id) != eid || int'(frame_index) != eix) addr_err++;
      if (query_ready) rdy_err++;
      i++;
      @(negedge clk);
    end
    chk("pred_seen", pred_valid, 1);
    chk("latency", cyc - hs, NC*NF + 1);
    chk("addr_sweep_errors", addr_err, 0);
    chk("ready_low_in_search", rdy_err, 0);
  endtask

  task automatic accept(input int hold);
    int drop;
    drop = 0;
    for (int i = 0; i < hold; i++) begin
      pred_ready = 1'b0;
      @(negedge clk);
      if (!pred_valid) drop++;
    end
    chk("valid_held", drop, 0);
    pred_ready = 1'b1;
    @(negedge clk);
    pred_ready = 1'b0;
    chk("valid_cleared", pred_valid, 0);
    chk("ready_after_accept", query_ready, 1);
  endtask

  task automatic set_weights(input int w0, w1, w2, w3, w4, w5, w6, w7);
    int wt [NC];
    wt = '{w0, w1, w2, w3, w4, w5, w6, w7};
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < NF; j++)
        cmem[k][j] = qv[j] ^ (ones(wt[k]) << j);
  endtask

  initial begin
    int hs, found;
    @(negedge clk);
    do_reset();
    chk_en = 1'b1;

    // Exact match on class 5; pred_ready held high beforehand must be harmless.
    qv = '{64'h0123_4567_89AB_CDEF, 64'hF0F0_1234_5678_9ABC, 64'hDEAD_BEEF_CAFE_BABE};
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < NF; j++) cmem[k][j] = (k == 5) ? qv[j] : ~qv[j];
    model();
    pred_ready = 1'b1;
    load(16'hFFFF, hs);
    run_sweep(hs);
    chk("exact_class", pred_class, 5);
    chk("exact_dist", pred_dist, 0);
    accept(0);

    // Tie between classes 2 and 6 at distance 10.
    qv = '{64'hA5A5_5A5A_0F0F_F0F0, 64'h1111_2222_4444_8888, 64'h7777_0000_FFFF_3C3C};
    for (int k = 0; k < NC; k++) begin
      if (k == 2 || k == 6) begin
        cmem[k][0] = qv[0];
        cmem[k][1] = qv[1] ^ 64'h3FF;
        cmem[k][2] = qv[2];
      end else begin
        cmem[k][0] = ~qv[0];
        cmem[k][1] = qv[1];
        cmem[k][2] = qv[2] ^ ones(k);
      end
    end
    model();
    load(16'hFFFF, hs);
    run_sweep(hs);
    chk("tie_class", pred_class, 2);
    chk("tie_dist", pred_dist, 10);
    accept(0);

    // Worst case: full 192-bit distance on every class.
    qv = '{'1, '1, '1};
    for (int k = 0; k < NC; k++)
      for (int j = 0; j < NF; j++) cmem[k][j] = '0;
    model();
    load(16'hFFFF, hs);
    run_sweep(hs);
    chk("worst_class", pred_class, 0);
    chk("worst_dist", pred_dist, 192);
    accept(0);

    // Load gaps 1-0-0-1-1 and 10 cycles of backpressure in DONE.
    qv = '{64'h0F1E_2D3C_4B5A_6978, 64'h8796_A5B4_C3D2_E1F0, 64'h1357_9BDF_2468_ACE0};
    set_weights(30, 25, 40, 12, 7, 33, 20, 9);
    model();
    load(16'h0019, hs);
    chk("ready_low_after_load", query_ready, 0);
    run_sweep(hs);
    chk("gap_class", pred_class, 4);
    chk("gap_dist", pred_dist, 21);
    accept(10);

    // Reset while the sweep is at address (3,1).
    qv = '{64'hFFFF_0000_FFFF_0000, 64'h0000_FFFF_0000_FFFF, 64'hCCCC_3333_CCCC_3333};
    set_weights(1, 2, 3, 4, 5, 6, 7, 8);
    model();
    load(16'hFFFF, hs);
    found = 0;
    for (int i = 0; i < 40 && found == 0; i++) begin
      if (frame_id == 3'd3 && frame_index == 2'd1) found = 1;
      else @(negedge clk);
    end
    chk("reached_3_1", found, 1);
    rst = 1'b1;
    @(negedge clk);
    chk_zero_outputs("abort");
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_abort", query_ready, 1);

    // Fresh query after the aborted one.
    qv = '{64'h2468_1357_ACE0_BDF9, 64'h9999_6666_AAAA_5555, 64'h0000_0000_FFFF_FFFF};
    set_weights(50, 45, 40, 35, 30, 25, 8, 60);
    model();
    load(16'hFFFF, hs);
    run_sweep(hs);
    chk("post_abort_class", pred_class, 6);
    chk("post_abort_dist", pred_dist, 24);
    accept(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "watchdog");
  end

endmodule
